seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the shared 7-segment decoder path. It accepts a DIGITS-nibble hex value from the upcounter over a valid/ready handshake and double-buffers it. It then sequences one digit at a time onto a single segment bus with active-low common-anode enables, guard blanking and optional leading-zero suppression. It sits between the counter datapath and the board display pins.

---
 rtl/seg7_scan_ctrl_if.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Value handshake between the counter datapath (master) and the scan controller (slave).
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value_in;
    logic                value_valid;
    logic                value_ready;

    modport master (output value_in, output value_valid, input  value_ready);
    modport slave  (input  value_in, input  value_valid, output value_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: double-buffered hex value, one digit per slot, 1-cycle guard blank.
// Outputs are registered; value_ready drops while the pending buffer is full and frees at the frame boundary.
module seg7_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    seg7_scan_ctrl_if.slave   s_val,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n,
    output logic              frame_done
);
    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(PRESCALE);
    localparam int VW = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    logic [1:0]        r_state;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;
    logic [VW-1:0]     r_disp;
    logic [VW-1:0]     r_pend;
    logic              r_pend_full;
    logic [6:0]        r_seg_n;
    logic [DIGITS-1:0] r_an_n;
    logic              r_frame_done;

    logic [1:0]        w_state_nxt;
    logic [IW-1:0]     w_idx_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_load;
    logic              w_fd_nxt;
    logic              w_xfer;
    logic [VW-1:0]     w_disp_nxt;
    logic [DIGITS-1:0] w_hi_zero;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic [6:0]        w_seg_nxt;
    logic [DIGITS-1:0] w_an_nxt;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0: f_decode = 7'b0000001;
            4'h1: f_decode = 7'b1001111;
            4'h2: f_decode = 7'b0010010;
            4'h3: f_decode = 7'b0000110;
            4'h4: f_decode = 7'b1001100;
            4'h5: f_decode = 7'b0100100;
            4'h6: f_decode = 7'b0100000;
            4'h7: f_decode = 7'b0001111;
            4'h8: f_decode = 7'b0000000;
            4'h9: f_decode = 7'b0000100;
            4'hA: f_decode = 7'b0001000;
            4'hB: f_decode = 7'b1100000;
            4'hC: f_decode = 7'b0110001;
            4'hD: f_decode = 7'b1000010;
            4'hE: f_decode = 7'b0110000;
            default: f_decode = 7'b0111000;
        endcase
    endfunction

    assign w_xfer            = s_val.value_valid & ~r_pend_full;
    assign s_val.value_ready = ~r_pend_full;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_load      = 1'b0;
        w_fd_nxt    = 1'b0;
        if (!enable) begin
            w_state_nxt = S_IDLE;
            w_idx_nxt   = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SHOW;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_load      = 1'b1;
                end
                S_SHOW: begin
                    if (r_cnt == CW'(PRESCALE - 1)) begin
                        w_state_nxt = S_GUARD;
                        w_cnt_nxt   = '0;
                        w_fd_nxt    = (r_idx == IW'(DIGITS - 1));
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_GUARD: begin
                    w_state_nxt = S_SHOW;
                    w_cnt_nxt   = '0;
                    if (r_idx == IW'(DIGITS - 1)) begin
                        w_idx_nxt = '0;
                        w_load    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IW'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A transfer landing on a load point bypasses the pending buffer.
    always_comb begin
        w_disp_nxt = r_disp;
        if (w_load) begin
            if (w_xfer)
                w_disp_nxt = s_val.value_in;
            else if (r_pend_full)
                w_disp_nxt = r_pend;
        end
    end

    // w_hi_zero[i]: nibbles i..DIGITS-1 of the next display value are all zero.
    always_comb begin
        logic acc;
        acc       = 1'b1;
        w_hi_zero = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            acc          = acc & (w_disp_nxt[4*i +: 4] == 4'h0);
            w_hi_zero[i] = acc;
        end
    end

    assign w_nib   = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
    assign w_blank = (BLANK_LZ != 0) && (w_idx_nxt != '0) && w_hi_zero[w_idx_nxt];

    always_comb begin
        w_seg_nxt = 7'h7F;
        w_an_nxt  = '1;
        if (w_state_nxt == S_SHOW && !w_blank) begin
            w_seg_nxt = f_decode(w_nib);
            w_an_nxt  = ~(DIGITS'(1) << w_idx_nxt);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_disp       <= '0;
            r_pend       <= '0;
            r_pend_full  <= 1'b0;
            r_seg_n      <= 7'h7F;
            r_an_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_cnt        <= w_cnt_nxt;
            r_disp       <= w_disp_nxt;
            r_seg_n      <= w_seg_nxt;
            r_an_n       <= w_an_nxt;
            r_frame_done <= w_fd_nxt;
            if (w_load) begin
                if (!w_xfer && r_pend_full)
                    r_pend_full <= 1'b0;
            end else if (w_xfer) begin
                r_pend      <= s_val.value_in;
                r_pend_full <= 1'b1;
            end
        end
    end

    assign seg_n      = r_seg_n;
    assign an_n       = r_an_n;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (leading-zero blanking off/on) share one stimulus stream.
module tb_seg7_scan_ctrl;
    localparam int D  = 4;
    localparam int P  = 4;
    localparam int FL = D * (P + 1);

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b1;
    logic        enable = 1'b0;
    logic        vld    = 1'b0;
    logic [15:0] vin    = 16'h0;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if #(.DIGITS(D)) u_if0 ();
    seg7_scan_ctrl_if #(.DIGITS(D)) u_if1 ();
    assign u_if0.value_in    = vin;
    assign u_if0.value_valid = vld;
    assign u_if1.value_in    = vin;
    assign u_if1.value_valid = vld;

    logic [6:0]   seg0, seg1;
    logic [D-1:0] an0, an1;
    logic         fd0, fd1;

    seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_LZ(0)) u_dut0 (
        .clk(clk), .reset(rst_n), .enable(enable), .s_val(u_if0),
        .seg_n(seg0), .an_n(an0), .frame_done(fd0));
    seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P), .BLANK_LZ(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .enable(enable), .s_val(u_if1),
        .seg_n(seg1), .an_n(an1), .frame_done(fd1));

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tbl [16];
    initial seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Model: m_t is the cycle position inside the running frame.
    bit          m_run   = 0;
    int          m_t     = 0;
    logic [15:0] m_disp  = 16'h0;
    logic [15:0] m_pend  = 16'h0;
    bit          m_pfull = 0;

    always @(posedge clk or negedge rst_n) begin : model
        bit xfer, load;
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_disp = 16'h0; m_pend = 16'h0; m_pfull = 0;
        end else begin
            xfer = vld && !m_pfull;
            load = enable && (!m_run || m_t == FL - 1);
            if (!enable) begin
                m_run = 0; m_t = 0;
            end else if (!m_run) begin
                m_run = 1; m_t = 0;
            end else begin
                m_t = (m_t + 1) % FL;
            end
            if (load) begin
                if (xfer) m_disp = vin;
                else if (m_pfull) begin m_disp = m_pend; m_pfull = 0; end
            end else if (xfer) begin
                m_pend = vin; m_pfull = 1;
            end
        end
    end

    // Packed as {3'b0, frame_done, value_ready, an_n, seg_n}.
    function automatic logic [15:0] exp_vec(input bit blz);
        int slot, ph;
        logic [6:0] s;
        logic [3:0] a;
        logic f;
        s = 7'h7F; a = 4'hF; f = 1'b0;
        if (m_run) begin
            slot = m_t / (P + 1);
            ph   = m_t % (P + 1);
            if (ph == P) begin
                f = (slot == D - 1);
            end else if (!(blz && slot > 0 && (m_disp >> (4 * slot)) == 16'h0)) begin
                s = seg_tbl[(m_disp >> (4 * slot)) & 16'hF];
                a = ~(4'b0001 << slot);
            end
        end
        return {3'b000, f, !m_pfull, a, s};
    endfunction

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        chk("scan_lz0", {3'b000, fd0, u_if0.value_ready, an0, seg0}, exp_vec(1'b0));
        chk("scan_lz1", {3'b000, fd1, u_if1.value_ready, an1, seg1}, exp_vec(1'b1));
    end

    int k = 0;
    task automatic to_k(input int tgt);
        while (k < tgt) begin
            @(posedge clk); #1; k++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_state", {3'b000, fd0, u_if0.value_ready, an0, seg0}, {3'b000, 1'b0, 1'b1, 4'hF, 7'h7F});
        rst_n = 1'b1;
        tick(1);

        // First offer bypasses straight into the display on IDLE->SHOW.
        enable = 1'b1; vld = 1'b1; vin = 16'h12AF;
        tick(1); k = 0;
        chk("accept_first", {15'h0, u_if0.value_ready}, 16'h1);
        chk("slot_F", {5'h0, an0, seg0}, {5'h0, 4'b1110, 7'b0111000});
        vld = 1'b0;
        to_k(4);  chk("guard0", {5'h0, an0, seg0}, {5'h0, 4'b1111, 7'h7F});
        to_k(5);  chk("slot_A", {5'h0, an0, seg0}, {5'h0, 4'b1101, 7'b0001000});
        to_k(10); chk("slot_2", {5'h0, an0, seg0}, {5'h0, 4'b1011, 7'b0010010});
        to_k(15); chk("slot_1", {5'h0, an0, seg0}, {5'h0, 4'b0111, 7'b1001111});
        to_k(18); chk("fd_low", {15'h0, fd0}, 16'h0);
        to_k(19); chk("fd_pulse", {15'h0, fd0}, 16'h1);
        to_k(20); chk("frame2_F", {4'h0, fd0, an0, seg0}, {4'h0, 1'b0, 4'b1110, 7'b0111000});

        // Leading-zero value loaded at the next boundary.
        vld = 1'b1; vin = 16'h0070;
        to_k(21); vld = 1'b0;
        chk("pend_busy", {15'h0, u_if0.value_ready}, 16'h0);
        to_k(40);
        chk("lz_ready", {15'h0, u_if1.value_ready}, 16'h1);
        chk("lz_d0", {5'h0, an1, seg1}, {5'h0, 4'b1110, 7'b0000001});
        vld = 1'b1; vin = 16'h2222;
        to_k(41); vld = 1'b0;
        to_k(45); chk("lz_d1", {5'h0, an1, seg1}, {5'h0, 4'b1101, 7'b0001111});
        to_k(50); chk("lz_d2_dark", {5'h0, an1, seg1}, {5'h0, 4'b1111, 7'h7F});
        chk("nolz_d2", {5'h0, an0, seg0}, {5'h0, 4'b1011, 7'b0000001});
        to_k(55); chk("lz_d3_dark", {5'h0, an1, seg1}, {5'h0, 4'b1111, 7'h7F});

        // 2222 shown from k=60; 1111 waits in pending, a further offer stalls.
        to_k(61); vld = 1'b1; vin = 16'h1111;
        to_k(62); vin = 16'h3333;
        chk("stall_ready", {15'h0, u_if0.value_ready}, 16'h0);
        to_k(75); chk("still_2222", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b0, 4'b0111, 7'b0010010});
        to_k(80); vld = 1'b0;
        chk("swap_1111", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b1, 4'b1110, 7'b1001111});

        // Transfer exactly on the frame-boundary edge.
        to_k(99); vld = 1'b1; vin = 16'h00B4;
        to_k(100); vld = 1'b0;
        chk("bypass_d0", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b1, 4'b1110, 7'b1001100});
        to_k(105); chk("bypass_d1", {5'h0, an0, seg0}, {5'h0, 4'b1101, 7'b1100000});
        to_k(110); chk("bypass_lz_d2", {5'h0, an1, seg1}, {5'h0, 4'b1111, 7'h7F});

        // Drop enable during digit 2; handshake keeps working while dark.
        to_k(131); enable = 1'b0;
        to_k(132); chk("disable_dark", {4'h0, fd0, an0, seg0}, {4'h0, 1'b0, 4'b1111, 7'h7F});
        vld = 1'b1; vin = 16'h5A5A;
        tick(1); vld = 1'b0;
        chk("idle_accept", {15'h0, u_if0.value_ready}, 16'h0);
        tick(1); enable = 1'b1;
        tick(1);
        chk("reenable_d0", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b1, 4'b1110, 7'b0001000});
        vld = 1'b1; vin = 16'h7777;
        tick(1); vld = 1'b0;
        tick(2); chk("full_slot", {4'h0, u_if0.value_ready, an0}, {4'h0, 1'b0, 4'b1110});
        tick(1); chk("guard_reen", {5'h0, an0, seg0}, {5'h0, 4'b1111, 7'h7F});

        // Asynchronous reset pulse in the middle of the guard cycle.
        #2 rst_n = 1'b0;
        #1 chk("async_rst", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b1, 4'b1111, 7'h7F});
        #8 rst_n = 1'b1;
        tick(1);
        chk("post_rst_d0", {4'h0, u_if0.value_ready, an0, seg0}, {4'h0, 1'b1, 4'b1110, 7'b0000001});
        tick(5);
        chk("post_rst_lz", {5'h0, an1, seg1}, {5'h0, 4'b1111, 7'h7F});
        chk("post_rst_d1", {5'h0, an0, seg0}, {5'h0, 4'b1101, 7'b0000001});
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: stimulus did not complete, got timeout, expected finish");
        $fatal(1);
    end
endmodule
